// File: rtl/glitch_pkg.sv
// Shared definitions for the glitch sweep sequencer.
//
// Contents:
//   sweep_state_t       - sequencer state encoding.
//   DELAY_W, CNT_W      - delay and hit/miss counter widths.
//   TIMER_W             - width of the shared timeout counter.
//   CLK_HZ              - system clock frequency the default timings assume.
//   *_DEF               - default ARM / WINDOW / target-reset timings.
//   sat_inc()           - saturating increment for the hit/miss counters.
package glitch_pkg;

    localparam int DELAY_W = 32;
    localparam int CNT_W   = 16;
    localparam int TIMER_W = 32;

    localparam int unsigned CLK_HZ = 48_000_000;

    // 1 s to see a trigger, 10 ms success window, 100 us target reset.
    localparam int unsigned ARM_TIMEOUT_DEF    = CLK_HZ;
    localparam int unsigned WINDOW_CYCLES_DEF  = CLK_HZ / 100;
    localparam int unsigned TGT_RST_CYCLES_DEF = CLK_HZ / 10_000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ARM,
        ST_WINDOW,
        ST_TRST,
        ST_NEXT,
        ST_DONE
    } sweep_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == '1) ? value : value + CNT_W'(1);
    endfunction

endpackage

// File: rtl/sweep_timer.sv
// Loadable down-counter with a zero flag, shared by the ARM, WINDOW and
// target-reset timeouts of the sweep sequencer.
//
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous active-low reset
//   load        in   load load_value this cycle (wins over counting)
//   load_value  in   value to load; the count reaches zero load_value
//                    cycles later
//   zero        out  count is zero (counter sticks at zero)
module sweep_timer
    import glitch_pkg::*;
#(
    parameter int WIDTH = TIMER_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/glitch_sweep_sequencer.sv
// Glitch campaign sequencer: steps the trigger delay from sweep_start to
// sweep_end (inclusive) by sweep_step, running `repeats` attempts per delay.
// Each attempt loads the delay, arms the trigger detector, opens the success
// window after a trigger, then holds the target in reset before the next one.
//
// Optional build macro GLITCH_STOP_ON_HIT_EN: when defined, a success inside
// the window ends the sweep on the next cycle without resetting the target,
// leaving it in its glitched state for inspection.
//
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   start                        one-cycle pulse, begins a sweep from IDLE
//   abort                        level, returns to IDLE on the next cycle
//   sweep_start/end/step,repeats sweep parameters, captured on start
//   trigger, success             detector pulses (ignored while unarmed)
//   delay, set_delay             delay value and its load strobe
//   trigger_arm, success_arm     detector arm levels
//   target_rst_n                 active-low target reset
//   busy, done                   activity level, completion pulse
//   hit, hit_delay               success pulse and the delay that produced it
//   hit_count, miss_count        saturating per-sweep counters
module glitch_sweep_sequencer
    import glitch_pkg::*;
#(
    parameter int unsigned ARM_TIMEOUT    = ARM_TIMEOUT_DEF,
    parameter int unsigned WINDOW_CYCLES  = WINDOW_CYCLES_DEF,
    parameter int unsigned TGT_RST_CYCLES = TGT_RST_CYCLES_DEF,
    parameter int unsigned REPEAT_W       = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [DELAY_W-1:0]  sweep_start,
    input  logic [DELAY_W-1:0]  sweep_end,
    input  logic [15:0]         sweep_step,
    input  logic [REPEAT_W-1:0] repeats,
    input  logic                trigger,
    input  logic                success,
    output logic [DELAY_W-1:0]  delay,
    output logic                set_delay,
    output logic                trigger_arm,
    output logic                success_arm,
    output logic                target_rst_n,
    output logic                busy,
    output logic                done,
    output logic                hit,
    output logic [DELAY_W-1:0]  hit_delay,
    output logic [CNT_W-1:0]    hit_count,
    output logic [CNT_W-1:0]    miss_count
);

    sweep_state_t        state_q, state_d;
    logic [DELAY_W-1:0]  delay_q, delay_d;
    logic [DELAY_W-1:0]  end_q, end_d;
    logic [15:0]         step_q, step_d;
    logic [REPEAT_W-1:0] rep_q, rep_d;
    logic [REPEAT_W-1:0] rep_init_q, rep_init_d;
    logic [DELAY_W-1:0]  hit_delay_q, hit_delay_d;
    logic [CNT_W-1:0]    hit_count_q, hit_count_d;
    logic [CNT_W-1:0]    miss_count_q, miss_count_d;
    logic                set_delay_q, set_delay_d;
    logic                trigger_arm_q, trigger_arm_d;
    logic                success_arm_q, success_arm_d;
    logic                target_rst_n_q, target_rst_n_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                hit_q, hit_d;

    logic [REPEAT_W-1:0] rep_norm;
    logic [REPEAT_W-1:0] rep_dec;
    logic [DELAY_W:0]    next_sum;
    logic                timer_load;
    logic [TIMER_W-1:0]  timer_value;
    logic                timer_zero;

    assign rep_norm = (repeats == '0) ? REPEAT_W'(1) : repeats;
    assign rep_dec  = rep_q - REPEAT_W'(1);
    // One extra bit so a step past 0xFFFFFFFF ends the sweep instead of wrapping.
    assign next_sum = {1'b0, delay_q} + {{(DELAY_W - 15){1'b0}}, step_q};

    sweep_timer #(.WIDTH(TIMER_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load),
        .load_value (timer_value),
        .zero       (timer_zero)
    );

    // Next-state logic. Timeouts are loaded with N-1 on entry so each timed
    // state lasts exactly N cycles; all outputs are registered copies of what
    // the next state implies, so they line up with the state register.
    always_comb begin
        state_d      = state_q;
        delay_d      = delay_q;
        end_d        = end_q;
        step_d       = step_q;
        rep_d        = rep_q;
        rep_init_d   = rep_init_q;
        hit_delay_d  = hit_delay_q;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        hit_d        = 1'b0;
        timer_load   = 1'b0;
        timer_value  = '0;

        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        end_d        = sweep_end;
                        step_d       = (sweep_step == '0) ? 16'd1 : sweep_step;
                        rep_d        = rep_norm;
                        rep_init_d   = rep_norm;
                        hit_delay_d  = '0;
                        hit_count_d  = '0;
                        miss_count_d = '0;
                        if (sweep_start > sweep_end) begin
                            state_d = ST_DONE;
                        end else begin
                            delay_d = sweep_start;
                            state_d = ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    state_d     = ST_ARM;
                    timer_load  = 1'b1;
                    timer_value = TIMER_W'(ARM_TIMEOUT - 1);
                end
                ST_ARM: begin
                    if (trigger) begin
                        state_d     = ST_WINDOW;
                        timer_load  = 1'b1;
                        timer_value = TIMER_W'(WINDOW_CYCLES - 1);
                    end else if (timer_zero) begin
                        miss_count_d = sat_inc(miss_count_q);
                        state_d      = ST_TRST;
                        timer_load   = 1'b1;
                        timer_value  = TIMER_W'(TGT_RST_CYCLES - 1);
                    end
                end
                ST_WINDOW: begin
                    if (success) begin
                        hit_d       = 1'b1;
                        hit_delay_d = delay_q;
                        hit_count_d = sat_inc(hit_count_q);
                    end
`ifdef GLITCH_STOP_ON_HIT_EN
                    if (success) begin
                        state_d = ST_DONE;
                    end else if (timer_zero) begin
                        state_d     = ST_TRST;
                        timer_load  = 1'b1;
                        timer_value = TIMER_W'(TGT_RST_CYCLES - 1);
                    end
`else
                    if (timer_zero) begin
                        state_d     = ST_TRST;
                        timer_load  = 1'b1;
                        timer_value = TIMER_W'(TGT_RST_CYCLES - 1);
                    end
`endif
                end
                ST_TRST: begin
                    if (timer_zero) begin
                        state_d = ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (rep_dec != '0) begin
                        rep_d   = rep_dec;
                        state_d = ST_LOAD;
                    end else begin
                        rep_d = rep_init_q;
                        if (next_sum[DELAY_W] || (next_sum[DELAY_W-1:0] > end_q)) begin
                            state_d = ST_DONE;
                        end else begin
                            delay_d = next_sum[DELAY_W-1:0];
                            state_d = ST_LOAD;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        set_delay_d    = (state_d == ST_LOAD);
        trigger_arm_d  = (state_d == ST_ARM);
        success_arm_d  = (state_d == ST_WINDOW);
        target_rst_n_d = (state_d != ST_TRST);
        busy_d         = !((state_d == ST_IDLE) || (state_d == ST_DONE));
        done_d         = (state_d == ST_DONE);
    end

    // State and registered outputs; everything returns to idle values on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            delay_q        <= '0;
            end_q          <= '0;
            step_q         <= '0;
            rep_q          <= '0;
            rep_init_q     <= '0;
            hit_delay_q    <= '0;
            hit_count_q    <= '0;
            miss_count_q   <= '0;
            set_delay_q    <= 1'b0;
            trigger_arm_q  <= 1'b0;
            success_arm_q  <= 1'b0;
            target_rst_n_q <= 1'b1;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            hit_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            delay_q        <= delay_d;
            end_q          <= end_d;
            step_q         <= step_d;
            rep_q          <= rep_d;
            rep_init_q     <= rep_init_d;
            hit_delay_q    <= hit_delay_d;
            hit_count_q    <= hit_count_d;
            miss_count_q   <= miss_count_d;
            set_delay_q    <= set_delay_d;
            trigger_arm_q  <= trigger_arm_d;
            success_arm_q  <= success_arm_d;
            target_rst_n_q <= target_rst_n_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            hit_q          <= hit_d;
        end
    end

    assign delay        = delay_q;
    assign set_delay    = set_delay_q;
    assign trigger_arm  = trigger_arm_q;
    assign success_arm  = success_arm_q;
    assign target_rst_n = target_rst_n_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign hit          = hit_q;
    assign hit_delay    = hit_delay_q;
    assign hit_count    = hit_count_q;
    assign miss_count   = miss_count_q;

endmodule

// File: tb/tb_glitch_sweep_sequencer.sv
// Self-checking bench for glitch_sweep_sequencer with shortened timings.
// The expected delay sequence of each sweep is computed up front from the
// sweep parameters; trigger/success are then driven at random points and
// every attempt's phase lengths, strobes and final counters are compared.
// Follows GLITCH_STOP_ON_HIT_EN the same way the design does.
module tb_glitch_sweep_sequencer;

    localparam int ARM_TO   = 20;
    localparam int WIN      = 8;
    localparam int TRST     = 5;
    localparam int REPEAT_W = 8;

`ifdef GLITCH_STOP_ON_HIT_EN
    localparam bit STOP_ON_HIT = 1'b1;
`else
    localparam bit STOP_ON_HIT = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                start = 1'b0;
    logic                abort = 1'b0;
    logic [31:0]         sweep_start = '0;
    logic [31:0]         sweep_end = '0;
    logic [15:0]         sweep_step = '0;
    logic [REPEAT_W-1:0] repeats = '0;
    logic                trigger = 1'b0;
    logic                success = 1'b0;
    logic [31:0]         delay;
    logic                set_delay;
    logic                trigger_arm;
    logic                success_arm;
    logic                target_rst_n;
    logic                busy;
    logic                done;
    logic                hit;
    logic [31:0]         hit_delay;
    logic [15:0]         hit_count;
    logic [15:0]         miss_count;

    int checks = 0;
    int errors = 0;

    glitch_sweep_sequencer #(
        .ARM_TIMEOUT    (ARM_TO),
        .WINDOW_CYCLES  (WIN),
        .TGT_RST_CYCLES (TRST),
        .REPEAT_W       (REPEAT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .sweep_start  (sweep_start),
        .sweep_end    (sweep_end),
        .sweep_step   (sweep_step),
        .repeats      (repeats),
        .trigger      (trigger),
        .success      (success),
        .delay        (delay),
        .set_delay    (set_delay),
        .trigger_arm  (trigger_arm),
        .success_arm  (success_arm),
        .target_rst_n (target_rst_n),
        .busy         (busy),
        .done         (done),
        .hit          (hit),
        .hit_delay    (hit_delay),
        .hit_count    (hit_count),
        .miss_count   (miss_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired before the bench completed");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step_cycle();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Runs one full sweep from IDLE and leaves the DUT back in IDLE at a negedge.
    task automatic applyStimulus(input logic [31:0] s_start, input logic [31:0] s_end,
                                 input logic [15:0] s_step, input logic [REPEAT_W-1:0] s_reps,
                                 input int trig_pct, input int succ_pct,
                                 input bit only_at, input logic [31:0] succ_delay);
        logic [31:0] exp_delays[$];
        logic [32:0] d;
        logic [31:0] exp_hit_delay;
        int          step_eff;
        int          reps_eff;
        int          exp_hits;
        int          exp_misses;
        int          trig_at;
        int          succ_at;
        int          arm_cycles;
        int          win_cycles;
        int          rst_cycles;
        int          stray_arm;
        int          hit_obs;
        bit          stopped;
        bit          stop_now;
        bit          want_hit;

        // Reference: every delay from start to end by step (no wrap), each repeated.
        step_eff = (s_step == 16'd0) ? 1 : int'(s_step);
        reps_eff = (s_reps == '0) ? 1 : int'(s_reps);
        d = {1'b0, s_start};
        while (d <= {1'b0, s_end}) begin
            for (int r = 0; r < reps_eff; r++) exp_delays.push_back(d[31:0]);
            d = d + 33'(step_eff);
        end

        exp_hits = 0;
        exp_misses = 0;
        exp_hit_delay = '0;
        stopped = 1'b0;

        sweep_start = s_start;
        sweep_end   = s_end;
        sweep_step  = s_step;
        repeats     = s_reps;
        start = 1'b1;
        step_cycle();
        start = 1'b0;

        for (int i = 0; i < exp_delays.size() && !stopped; i++) begin
            checkOutput("load_set_delay", set_delay, 1);
            checkOutput("load_delay", delay, exp_delays[i]);
            checkOutput("load_busy", busy, 1);

            trig_at = ($urandom_range(99) < trig_pct) ? int'($urandom_range(ARM_TO, 1)) : 0;
            want_hit = only_at ? (exp_delays[i] == succ_delay) : ($urandom_range(99) < succ_pct);
            succ_at = (trig_at != 0 && want_hit) ? int'($urandom_range(WIN, 1)) : 0;

            trigger = 1'($urandom_range(1));
            step_cycle();
            trigger = 1'b0;

            arm_cycles = 0;
            while (trigger_arm === 1'b1 && arm_cycles <= ARM_TO) begin
                arm_cycles++;
                trigger = (arm_cycles == trig_at);
                success = 1'($urandom_range(1));
                step_cycle();
            end
            trigger = 1'b0;
            success = 1'b0;
            checkOutput("arm_cycles", arm_cycles, (trig_at != 0) ? trig_at : ARM_TO);
            checkOutput("after_arm_success_arm", success_arm, (trig_at != 0) ? 1 : 0);
            if (trig_at == 0) exp_misses++;

            stop_now = STOP_ON_HIT && (succ_at != 0);
            if (trig_at != 0) begin
                hit_obs = 0;
                win_cycles = 0;
                while (success_arm === 1'b1 && win_cycles <= WIN) begin
                    win_cycles++;
                    hit_obs += int'(hit);
                    success = (win_cycles == succ_at);
                    trigger = 1'($urandom_range(1));
                    step_cycle();
                end
                success = 1'b0;
                trigger = 1'b0;
                hit_obs += int'(hit);
                checkOutput("window_cycles", win_cycles, stop_now ? succ_at : WIN);
                checkOutput("hit_pulses", hit_obs, (succ_at != 0) ? 1 : 0);
                if (succ_at != 0) begin
                    exp_hits++;
                    exp_hit_delay = exp_delays[i];
                    checkOutput("hit_delay_now", hit_delay, exp_hit_delay);
                end
            end

            checkOutput("post_attempt_done", done, stop_now ? 1 : 0);
            checkOutput("post_attempt_tgt_rst", target_rst_n, stop_now ? 1 : 0);

            if (stop_now) begin
                stopped = 1'b1;
            end else begin
                rst_cycles = 0;
                stray_arm = 0;
                while (target_rst_n === 1'b0 && rst_cycles <= TRST) begin
                    rst_cycles++;
                    stray_arm += int'(trigger_arm | success_arm);
                    trigger     = 1'($urandom_range(1));
                    success     = 1'($urandom_range(1));
                    start       = 1'($urandom_range(1));
                    sweep_start = $urandom;
                    sweep_end   = $urandom;
                    step_cycle();
                end
                trigger = 1'b0;
                success = 1'b0;
                start   = 1'b0;
                checkOutput("trst_cycles", rst_cycles, TRST);
                checkOutput("trst_arms_low", stray_arm, 0);
                checkOutput("next_quiet", {set_delay, trigger_arm, success_arm, done}, 0);
                step_cycle();
            end
        end

        checkOutput("done_pulse", done, 1);
        checkOutput("done_busy", busy, 0);
        checkOutput("done_set_delay", set_delay, 0);
        checkOutput("done_arms", {trigger_arm, success_arm}, 0);
        checkOutput("done_tgt_rst", target_rst_n, 1);
        checkOutput("hit_count", hit_count, exp_hits);
        checkOutput("miss_count", miss_count, exp_misses);
        if (exp_hits > 0) checkOutput("hit_delay", hit_delay, exp_hit_delay);
        step_cycle();
        checkOutput("done_one_cycle", done, 0);
        checkOutput("idle_set_delay", set_delay, 0);
        checkOutput("idle_hit_count_hold", hit_count, exp_hits);
    endtask

    initial begin
        $display("[TB] start, stop-on-hit build = %0d", STOP_ON_HIT);

        // Reset state.
        rst = 1'b0;
        repeat (2) step_cycle();
        checkOutput("rst_delay", delay, 0);
        checkOutput("rst_set_delay", set_delay, 0);
        checkOutput("rst_arms", {trigger_arm, success_arm}, 0);
        checkOutput("rst_tgt_rst", target_rst_n, 1);
        checkOutput("rst_busy_done_hit", {busy, done, hit}, 0);
        checkOutput("rst_hit_delay", hit_delay, 0);
        checkOutput("rst_counts", {hit_count, miss_count}, 0);
        rst = 1'b1;
        step_cycle();

        // Triggers every attempt, never a success.
        applyStimulus(32'd10, 32'd14, 16'd2, 8'd1, 100, 0, 1'b0, 32'd0);
        // Success only at delay 12.
        applyStimulus(32'd10, 32'd14, 16'd2, 8'd1, 100, 0, 1'b1, 32'd12);
        // Never triggers, two attempts at one delay.
        applyStimulus(32'd5, 32'd5, 16'd1, 8'd2, 0, 0, 1'b0, 32'd0);
        // Step overflows past 0xFFFFFFFF after the first attempt.
        applyStimulus(32'hFFFF_FFF0, 32'hFFFF_FFFF, 16'h0020, 8'd1, 100, 50, 1'b0, 32'd0);
        // Empty range.
        applyStimulus(32'd20, 32'd10, 16'd1, 8'd1, 100, 50, 1'b0, 32'd0);
        // Zero step and zero repeats behave as one.
        applyStimulus(32'd3, 32'd4, 16'd0, 8'd0, 50, 50, 1'b0, 32'd0);
        // Near the top of the range with a step that lands exactly past it.
        applyStimulus(32'hFFFF_FFFA, 32'hFFFF_FFFF, 16'd3, 8'd1, 80, 40, 1'b0, 32'd0);

        for (int k = 0; k < 6; k++) begin
            logic [31:0] rs;
            logic [31:0] re;
            rs = $urandom_range(1000);
            re = rs + $urandom_range(10);
            applyStimulus(rs, re, 16'($urandom_range(4)), 8'($urandom_range(3)), 70, 40, 1'b0, 32'd0);
        end

        // Abort in the success window.
        sweep_start = 32'd30;
        sweep_end   = 32'd40;
        sweep_step  = 16'd1;
        repeats     = 8'd1;
        start = 1'b1;
        step_cycle();
        start = 1'b0;
        step_cycle();
        trigger = 1'b1;
        step_cycle();
        trigger = 1'b0;
        step_cycle();
        checkOutput("abort_in_window", success_arm, 1);
        abort = 1'b1;
        step_cycle();
        abort = 1'b0;
        checkOutput("abort_arms", {trigger_arm, success_arm}, 0);
        checkOutput("abort_tgt_rst", target_rst_n, 1);
        checkOutput("abort_busy_done", {busy, done}, 0);
        begin
            int activity;
            activity = 0;
            repeat (4) begin
                step_cycle();
                activity += int'(done | set_delay | trigger_arm | busy);
            end
            checkOutput("abort_stays_idle", activity, 0);
        end

        // Asynchronous reset in the middle of target reset.
        sweep_start = 32'd50;
        sweep_end   = 32'd50;
        start = 1'b1;
        step_cycle();
        start = 1'b0;
        repeat (ARM_TO + 1) step_cycle();
        checkOutput("pre_reset_in_trst", target_rst_n, 0);
        checkOutput("pre_reset_miss", miss_count, 1);
        repeat (2) step_cycle();
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_rst_tgt_rst", target_rst_n, 1);
        checkOutput("async_rst_busy", busy, 0);
        checkOutput("async_rst_miss", miss_count, 0);
        checkOutput("async_rst_delay", delay, 0);
        step_cycle();
        rst = 1'b1;
        step_cycle();
        checkOutput("after_rst_idle", {busy, done, set_delay, trigger_arm, success_arm}, 0);

        // Normal operation resumes after reset.
        applyStimulus(32'd7, 32'd9, 16'd1, 8'd1, 80, 50, 1'b0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/glitch_sweep_sequencer.md
Name: glitch_sweep_sequencer

Overview:
Automates a glitch campaign by stepping the trigger delay over a programmed range. For each delay it repeats the attempt a set number of times. Each attempt arms the trigger and success edge detectors, waits for the trigger and then the success window, and power-cycles the target through its reset line. It sits between the host configuration registers and the existing trigger_delay and detect_edge instances, driving the delay, set_delay, trigger_arm and success_arm nets.

Parameters:
- ARM_TIMEOUT, 48_000_000: clk cycles to wait for trigger after arming (1 s at 48 MHz).
- WINDOW_CYCLES, 480_000: clk cycles success_arm stays high after trigger.
- TGT_RST_CYCLES, 4800: clk cycles target_rst_n is held low between attempts.
- REPEAT_W, 8: width of the per-delay repeat count.

Ports:
- clk  in  1  system clock, 48 MHz.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a sweep when idle.
- abort  in  1  level; forces return to IDLE.
- sweep_start  in  32  first delay value, sampled on start.
- sweep_end  in  32  last delay value (inclusive), sampled on start.
- sweep_step  in  16  delay increment, sampled on start; 0 is treated as 1.
- repeats  in  REPEAT_W  attempts per delay, sampled on start; 0 is treated as 1.
- trigger  in  1  pulse from the trigger detect_edge.
- success  in  1  pulse from the success detect_edge.
- delay  out  32  delay value to trigger_delay.
- set_delay  out  1  one-cycle load strobe.
- trigger_arm  out  1  level; arms the trigger detector.
- success_arm  out  1  level; arms the success detector.
- target_rst_n  out  1  active-low target reset.
- busy  out  1  high whenever the block is outside IDLE and DONE.
- done  out  1  one-cycle pulse at sweep completion.
- hit  out  1  one-cycle pulse per successful attempt.
- hit_delay  out  32  delay of the most recent hit.
- hit_count  out  16  hits in the current sweep; saturates at 0xFFFF.
- miss_count  out  16  attempts with no trigger; saturates at 0xFFFF.

Behaviour:
- Reset values: all outputs 0 except target_rst_n=1; state is IDLE.
- States: IDLE, LOAD, ARM, WINDOW, TRST, NEXT, DONE.
- IDLE: on start, latch the sweep parameters and clear the counters.
  - If sweep_start > sweep_end, go to DONE (zero attempts).
  - Otherwise delay=sweep_start and go to LOAD.
- LOAD (one cycle): set_delay=1, then go to ARM.
- ARM: trigger_arm=1.
  - On trigger: deassert trigger_arm in the same cycle, go to WINDOW.
  - After ARM_TIMEOUT cycles without trigger: miss_count++, go to TRST.
- WINDOW: success_arm=1 for WINDOW_CYCLES.
  - On success: pulse hit, hit_delay=delay, hit_count++.
  - Remaining in WINDOW after success is governed by the optional feature.
  - At window expiry: go to TRST.
- TRST: target_rst_n=0 for TRST_CYCLES; trigger_arm and success_arm are 0 throughout.
- NEXT (one cycle): decrement the repeat counter.
  - Repeat counter nonzero: go to LOAD with the same delay.
  - Otherwise compute delay+step in 33 bits and reload the repeat counter:
    - If the result > sweep_end or bit 32 is set: go to DONE.
    - Else delay=result, go to LOAD.
- DONE (one cycle): pulse done, go to IDLE. The counters and hit_delay hold until the next start.
- trigger and success are ignored in any state where their arm is low.
- trigger and timeout in the same cycle: trigger wins.
- success on the final WINDOW cycle counts as a hit.
- start while busy is ignored.
- abort: on the next cycle all arms drop, target_rst_n=1, go to IDLE; no done pulse.
- Asynchronous reset mid-sweep: everything returns to reset values immediately.

Optional Feature:
- Macro: GLITCH_STOP_ON_HIT_EN.
- Defined: a hit in WINDOW goes straight to DONE next cycle, skipping TRST. The target stays in its glitched state for inspection.
- Undefined: the sweep runs to completion and all hits are counted.

Decomposition:
- Shared package glitch_pkg holds:
  - the state enum sweep_state_t;
  - the width constants DELAY_W=32 and CNT_W=16;
  - the default timing constants, derived from CLK_HZ=48_000_000.
- One natural sub-module, sweep_timer: a loadable down-counter with a zero flag. It is instantiated once and reused for the ARM, WINDOW and TRST timeouts.

Test Plan:
1. start with start=10, end=14, step=2, repeats=1; trigger every attempt, no success. Expect set_delay with delay 10, 12, 14; three TRST pulses; one done; hit_count=0, miss_count=0.
2. Same range, success asserted only when delay=12. Expect hit pulse, hit_delay=12, hit_count=1. With GLITCH_STOP_ON_HIT_EN: done follows the hit, delay 14 is never loaded, and target_rst_n stays 1.
3. No trigger ever, repeats=2, start=end=5. Expect two ARM_TIMEOUT expiries, miss_count=2, done.
4. start=0xFFFFFFF0, end=0xFFFFFFFF, step=0x20. Expect one attempt at 0xFFFFFFF0, then done (overflow detected, no wrap to a small delay).
5. start=20, end=10. Expect done within 2 cycles, no set_delay, no arms asserted.
6. abort during WINDOW, then rst low mid-TRST on a second run. Expect IDLE with arms=0 and target_rst_n=1 after one cycle. Expect reset values asynchronously on rst low.
